conv1_layer_sequencer: RTL and testbench
========================================

# conv1_layer_sequencer

Frame-level controller for the first convolution stage. It accepts one 35×35 image as a valid/ready pixel stream and writes it into the conv layer's image buffer with linear addresses. It then pulses the conv layer's `layer_enable` and watches the conv layer's output-write strobe to detect completion. Finally it hands off to the pooling stage and waits for that stage's done, reporting frame completion or a watchdog error to the top-level controller.

## Interface
Parameters:
- `DATA_WIDTH`, 16, pixel width.
- `ADDR_WIDTH`, 16, image buffer address width.
- `IMG_PIXELS`, 1225, pixels per frame (35×35).
- `CONV_OUTPUTS`, 961, expected conv output writes per frame (31×31).
- `TIMEOUT_CYCLES`, 8192, watchdog limit for the CONV and POOL states.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin frame; sampled only in IDLE.
- `abort`  in  1  synchronous return to IDLE from any state.
- `pix_valid`  in  1  input pixel valid.
- `pix_data`  in  DATA_WIDTH  input pixel.
- `pix_ready`  out  1  sequencer accepts pixel.
- `img_data_wr_en`  out  1  conv image buffer write strobe.
- `img_data_in`  out  DATA_WIDTH  conv image buffer write data.
- `img_data_addr`  out  ADDR_WIDTH  conv image buffer write address.
- `layer_enable`  out  1  one-cycle conv start pulse.
- `pool_1_out_wr_en`  in  1  conv output write strobe (monitored only).
- `pool_enable`  out  1  one-cycle pool start pulse.
- `pool_done`  in  1  pool stage finished (level or pulse).
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky; set on timeout or count mismatch.
- `conv_out_count`  out  ADDR_WIDTH  conv writes counted for the last frame.

## Operation
- States: IDLE, LOAD, SETTLE, CONV, CWAIT, POOL, DONE.
- IDLE:
  - `start`=1 → LOAD.
  - Entering LOAD clears the pixel counter, `conv_out_count` and `error`.
- LOAD:
  - `pix_ready`=1.
  - Each `pix_valid&pix_ready` cycle registers a write: `img_data_wr_en`=1, `img_data_in`=`pix_data`, `img_data_addr`=pixel count. The pixel counter then increments.
  - After pixel IMG_PIXELS−1 is accepted: `pix_ready` drops the next cycle and the state goes to SETTLE.
- SETTLE:
  - Held for one cycle so the last buffer write lands.
  - `layer_enable`=1 for exactly that following cycle; state → CONV.
- CONV:
  - Each cycle with `pool_1_out_wr_en`=1 increments `conv_out_count`, saturating at all-ones.
  - The first high cycle moves the state to CWAIT.
- CWAIT:
  - Continues counting.
  - On the first cycle `pool_1_out_wr_en`=0: if `conv_out_count`≠CONV_OUTPUTS, set `error`. Either way, pulse `pool_enable` for 1 cycle and go to POOL.
- POOL: `pool_done`=1 → DONE.
- DONE: `frame_done`=1 for one cycle → IDLE.
- Watchdog:
  - The counter resets on entry to CONV and counts in CONV, CWAIT and POOL.
  - Reaching TIMEOUT_CYCLES sets `error` and forces IDLE with no `frame_done`.
- `abort` has priority over all transitions:
  - next state IDLE;
  - all strobes 0;
  - counters hold;
  - `error` unchanged.
- `start` outside IDLE is ignored.
- `pix_valid` outside LOAD is ignored and gets no ready.
- A mismatch in the conv count still completes the frame; `error` stays high until the next `start`.

## Timing
- Reset values:
  - all strobes 0; `pix_ready` 0; `busy` 0; `error` 0;
  - `img_data_addr`, `img_data_in`, `conv_out_count` all 0;
  - state IDLE.
- `start` at edge N:
  - `busy`=1 and `pix_ready`=1 from N+1.
  - The first accepted pixel at edge M appears on the buffer write port in cycle M+1.
- Full-rate stream, first pixel accepted at edge N+1:
  - last acceptance at N+1225;
  - last write in cycle N+1226 (SETTLE);
  - `layer_enable` high in cycle N+1227.
- Bubbles on `pix_valid` stall the address; no address skips.
- Falling edge of `pool_1_out_wr_en` seen at edge K → `pool_enable` high in cycle K+1.
- `pool_done` seen at edge P → `frame_done` in cycle P+1, `busy`=0 from P+2.
- `start` may be accepted in the cycle after DONE (back-to-back frames).
- Asynchronous reset mid-frame: all outputs drop immediately; the pixel counter restarts at 0 on the next `start`.

## Test plan
- Full-rate frame:
  - Stimulus: 1225 pixels with value=address; conv model emits 961 consecutive strobes after 7 cycles; `pool_done` 20 cycles later.
  - Required: addresses 0..1224 written once each; one `layer_enable`; one `pool_enable`; `conv_out_count`=961; `frame_done`=1; `error`=0.
- Throttled stream:
  - Stimulus: `pix_valid` high every 3rd cycle.
  - Required: 1225 writes with no gaps or duplicates in the address sequence; `layer_enable` exactly 2 cycles after the last acceptance.
- Count mismatch:
  - Stimulus: conv model emits 967 strobes.
  - Required: `conv_out_count`=967; `error`=1; `frame_done` still pulses; the next `start` clears `error`.
- Watchdog:
  - Stimulus: conv model never strobes.
  - Required: `error`=1 after 8192 CONV cycles, then IDLE; no `pool_enable`, no `frame_done`.
- Abort/start races:
  - Stimulus: `abort` at pixel 600; `start` during CONV.
  - Required: IDLE next cycle; no further writes; the mid-CONV `start` is ignored.
- Async reset:
  - Stimulus: `rst_n` low during POOL.
  - Required: all outputs 0 immediately; a new frame afterwards runs correctly from address 0.

Source files
------------

// File: rtl/conv1_layer_sequencer.sv
// Frame sequencer for the first conv stage: loads one image into the conv buffer,
// starts the conv layer, counts its output writes, then runs the pooling stage.
module conv1_layer_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int IMG_PIXELS     = 1225,
  parameter int CONV_OUTPUTS   = 961,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  img_data_wr_en,
  output logic [DATA_WIDTH-1:0] img_data_in,
  output logic [ADDR_WIDTH-1:0] img_data_addr,
  output logic                  layer_enable,
  input  logic                  pool_1_out_wr_en,
  output logic                  pool_enable,
  input  logic                  pool_done,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] conv_out_count
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(IMG_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] EXP_CONV = ADDR_WIDTH'(CONV_OUTPUTS);
  localparam logic [WD_WIDTH-1:0]   WD_LAST  = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    CONV   = 3'd3,
    CWAIT  = 3'd4,
    POOL   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] pix_cnt_r;
  logic [WD_WIDTH-1:0]   wd_cnt_r;
  logic                  wd_expired_s;

  function automatic logic [ADDR_WIDTH-1:0] sat_inc(input logic [ADDR_WIDTH-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ADDR_WIDTH'(1);
    end
  endfunction

  assign wd_expired_s = (wd_cnt_r == WD_LAST);

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      pix_cnt_r      <= '0;
      wd_cnt_r       <= '0;
      pix_ready      <= 1'b0;
      img_data_wr_en <= 1'b0;
      img_data_in    <= '0;
      img_data_addr  <= '0;
      layer_enable   <= 1'b0;
      pool_enable    <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      error          <= 1'b0;
      conv_out_count <= '0;
    end else begin
      img_data_wr_en <= 1'b0;
      layer_enable   <= 1'b0;
      pool_enable    <= 1'b0;
      frame_done     <= 1'b0;
      if (abort) begin
        // Counters and error hold so the aborted frame stays inspectable.
        state_r   <= IDLE;
        pix_ready <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              state_r        <= LOAD;
              pix_ready      <= 1'b1;
              busy           <= 1'b1;
              pix_cnt_r      <= '0;
              conv_out_count <= '0;
              error          <= 1'b0;
            end
          end
          LOAD: begin
            if (pix_valid) begin
              img_data_wr_en <= 1'b1;
              img_data_in    <= pix_data;
              img_data_addr  <= pix_cnt_r;
              pix_cnt_r      <= pix_cnt_r + ADDR_WIDTH'(1);
              if (pix_cnt_r == LAST_PIX) begin
                pix_ready <= 1'b0;
                state_r   <= SETTLE;
              end
            end
          end
          SETTLE: begin
            layer_enable <= 1'b1;
            wd_cnt_r     <= '0;
            state_r      <= CONV;
          end
          CONV, CWAIT, POOL: begin
            if (wd_expired_s) begin
              error   <= 1'b1;
              busy    <= 1'b0;
              state_r <= IDLE;
            end else begin
              wd_cnt_r <= wd_cnt_r + WD_WIDTH'(1);
              if (state_r == POOL) begin
                if (pool_done) begin
                  frame_done <= 1'b1;
                  state_r    <= DONE;
                end
              end else if (pool_1_out_wr_en) begin
                conv_out_count <= sat_inc(conv_out_count);
                state_r        <= CWAIT;
              end else if (state_r == CWAIT) begin
                // Burst ended: a count mismatch is flagged but the frame still completes.
                if (conv_out_count != EXP_CONV) begin
                  error <= 1'b1;
                end
                pool_enable <= 1'b1;
                state_r     <= POOL;
              end
            end
          end
          DONE: begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
          default: begin
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv1_layer_sequencer.sv
// Directed bench for conv1_layer_sequencer: a vector table for the load handshake,
// then full-frame sequences for throttling, count mismatch, watchdog, abort and reset.
module tb_conv1_layer_sequencer;

  localparam int IMG  = 1225;
  localparam int CONV = 961;
  localparam int WDOG = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_ready;
  logic        img_data_wr_en;
  logic [15:0] img_data_in;
  logic [15:0] img_data_addr;
  logic        layer_enable;
  logic        pool_1_out_wr_en = 1'b0;
  logic        pool_enable;
  logic        pool_done = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        error;
  logic [15:0] conv_out_count;

  conv1_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .img_data_wr_en(img_data_wr_en), .img_data_in(img_data_in), .img_data_addr(img_data_addr),
    .layer_enable(layer_enable), .pool_1_out_wr_en(pool_1_out_wr_en),
    .pool_enable(pool_enable), .pool_done(pool_done), .busy(busy),
    .frame_done(frame_done), .error(error), .conv_out_count(conv_out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_no = 0;
  int last_acc = 0;
  int le_edge = 0;

  // Write scoreboard and pulse counters, sampled on the falling edge.
  bit mon_en = 1'b0;
  int exp_addr = 0, wr_cnt = 0, wr_bad = 0, le_cnt = 0, pe_cnt = 0, fd_cnt = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (img_data_wr_en) begin
        if (img_data_addr != 16'(exp_addr) || img_data_in != 16'(exp_addr)) wr_bad++;
        exp_addr++;
        wr_cnt++;
      end
      if (layer_enable) le_cnt++;
      if (pool_enable) pe_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    exp_addr = 0; wr_cnt = 0; wr_bad = 0; le_cnt = 0; pe_cnt = 0; fd_cnt = 0;
    mon_en = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", pix_ready, 1);
  endtask

  // Offer pixels (value = address) every 'period' cycles until 'count' are accepted.
  task automatic load_pixels(input int period, input int count);
    int sent;
    int t;
    bit acc;
    sent = 0;
    t = 0;
    while (sent < count && t < 20000) begin
      pix_valid = (t % period == 0);
      pix_data  = 16'(sent);
      acc = pix_valid && pix_ready;
      step();
      if (acc) begin
        sent++;
        last_acc = edge_no;
      end
      t++;
    end
    pix_valid = 1'b0;
    check("pixels_accepted", sent, count);
  endtask

  task automatic wait_layer();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (layer_enable) begin
        got = 1'b1;
        le_edge = edge_no;
      end
    end
    check("layer_enable_seen", got, 1);
    // layer_enable is visible in the second cycle after the last acceptance edge.
    check("layer_enable_latency", le_edge - last_acc, 1);
  endtask

  // Conv model: 7 idle cycles (optionally poking start), n strobes, then falling edge.
  task automatic conv_burst(input int n, input bit exp_err, input bit poke);
    for (int i = 0; i < 7; i++) begin
      start = poke && (i == 3);
      step();
    end
    start = 1'b0;
    check("start_ignored_ready", pix_ready, 0);
    check("start_ignored_busy", busy, 1);
    pool_1_out_wr_en = 1'b1;
    repeat (n) step();
    pool_1_out_wr_en = 1'b0;
    step();
    check("pool_enable_timing", pool_enable, 1);
    check("conv_out_count", conv_out_count, n);
    check("conv_error", error, exp_err);
  endtask

  task automatic pool_finish();
    repeat (20) step();
    check("pool_wait_busy", busy, 1);
    pool_done = 1'b1;
    step();
    pool_done = 1'b0;
    check("frame_done_pulse", frame_done, 1);
    check("busy_in_done", busy, 1);
    step();
    check("frame_done_clear", frame_done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic frame_totals(input int writes, input int les, input int pes, input int fds);
    check("write_count", wr_cnt, writes);
    check("write_seq_errors", wr_bad, 0);
    check("layer_enable_count", le_cnt, les);
    check("pool_enable_count", pe_cnt, pes);
    check("frame_done_count", fd_cnt, fds);
  endtask

  typedef struct packed {
    logic        start;
    logic        abort;
    logic        pv;
    logic [15:0] pd;
    logic        rdy;
    logic        bsy;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int t0;
    bit wd_hit;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h000A, 1'b1, 1'b1, 1'b1, 16'd0, 16'h000A};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0077, 1'b1, 1'b1, 1'b0, 16'd0, 16'h000A};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h000B, 1'b1, 1'b1, 1'b1, 16'd1, 16'h000B};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h000C, 1'b1, 1'b1, 1'b1, 16'd2, 16'h000C};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0, 1'b0, 16'd2, 16'h000C};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0, 16'd2, 16'h000C};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'd2, 16'h000C};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b1, 1'b1, 16'd0, 16'h000F};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'd0, 16'h000F};

    #23;
    check("rst_busy", busy, 0);
    check("rst_ready", pix_ready, 0);
    check("rst_error", error, 0);
    check("rst_strobes", {img_data_wr_en, layer_enable, pool_enable, frame_done}, 0);
    check("rst_addr", img_data_addr, 0);
    check("rst_data", img_data_in, 0);
    check("rst_count", conv_out_count, 0);
    rst_n = 1'b1;
    step();

    // Load handshake, bubbles, ignored start/valid, abort and restart from address 0.
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].start; abort = vecs[i].abort;
      pix_valid = vecs[i].pv; pix_data = vecs[i].pd;
      step();
      check($sformatf("vec%0d_ready", i), pix_ready, vecs[i].rdy);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("vec%0d_wr_en", i), img_data_wr_en, vecs[i].wr);
      check($sformatf("vec%0d_addr", i), img_data_addr, vecs[i].addr);
      check($sformatf("vec%0d_data", i), img_data_in, vecs[i].data);
    end
    start = 1'b0; abort = 1'b0; pix_valid = 1'b0;
    step();

    // Full-rate frame with a start poke during CONV.
    mon_clear();
    do_start();
    load_pixels(1, IMG);
    wait_layer();
    conv_burst(CONV, 1'b0, 1'b1);
    pool_finish();
    frame_totals(IMG, 1, 1, 1);
    check("frame_a_error", error, 0);

    // Throttled stream, started in the cycle right after DONE.
    mon_clear();
    do_start();
    load_pixels(3, IMG);
    wait_layer();
    conv_burst(CONV, 1'b0, 1'b0);
    pool_finish();
    frame_totals(IMG, 1, 1, 1);

    // Count mismatch still completes; next start clears error.
    mon_clear();
    do_start();
    load_pixels(1, IMG);
    wait_layer();
    conv_burst(CONV + 6, 1'b1, 1'b0);
    pool_finish();
    frame_totals(IMG, 1, 1, 1);
    check("mismatch_error_sticky", error, 1);
    do_start();
    check("start_clears_error", error, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_to_idle", busy, 0);

    // Watchdog: conv never strobes.
    mon_clear();
    do_start();
    load_pixels(1, IMG);
    wait_layer();
    wd_hit = 1'b0;
    t0 = 0;
    for (int i = 0; i < WDOG + 100 && !wd_hit; i++) begin
      step();
      if (!busy) begin
        wd_hit = 1'b1;
        t0 = edge_no;
      end
    end
    check("watchdog_hit", wd_hit, 1);
    check("watchdog_cycles", t0 - le_edge, WDOG);
    check("watchdog_error", error, 1);
    frame_totals(IMG, 1, 0, 0);

    // Abort after 600 pixels: no further writes even with valid held high.
    mon_clear();
    do_start();
    load_pixels(1, 600);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", pix_ready, 0);
    check("abort_keeps_error", error, 0);
    pix_valid = 1'b1;
    repeat (10) step();
    pix_valid = 1'b0;
    step();
    frame_totals(600, 0, 0, 0);

    // Asynchronous reset while in POOL, then a clean frame from address 0.
    mon_clear();
    do_start();
    load_pixels(1, IMG);
    wait_layer();
    conv_burst(CONV, 1'b0, 1'b0);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_outputs", {pix_ready, img_data_wr_en, layer_enable, pool_enable, frame_done, error}, 0);
    check("areset_count", conv_out_count, 0);
    check("areset_addr", img_data_addr, 0);
    #3;
    rst_n = 1'b1;
    step();
    mon_clear();
    do_start();
    load_pixels(1, IMG);
    wait_layer();
    conv_burst(CONV, 1'b0, 1'b0);
    pool_finish();
    frame_totals(IMG, 1, 1, 1);
    check("post_reset_error", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
